// File: rtl/bnn_pkg.sv
// Shared definitions for the BNN weight-load path: default weight table,
// neuron count and the weight streamer state encoding.
package bnn_pkg;

    localparam int NUM_NEURONS  = 12;
    localparam int NUM_DEFAULTS = 12;

    // Power-on weights of the BNN core, words 0..11
    localparam logic [7:0] DEFAULT_WEIGHTS [NUM_DEFAULTS] = '{
        8'hA0, 8'h41, 8'h7A, 8'h18, 8'hED, 8'hB7,
        8'h67, 8'h3A, 8'hF9, 8'h62, 8'hF7, 8'h0F
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        GAP  = 2'd3
    } stream_state_t;

    // Default weight for word i; words beyond the default table reset to zero
    function automatic logic [7:0] default_weight(input int unsigned i);
        logic [7:0] w;
        w = '0;
        for (int unsigned k = 0; k < NUM_DEFAULTS; k++) begin
            if (k == i) begin
                w = DEFAULT_WEIGHTS[k];
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/bnn_weight_table.sv
// Weight table for the streamer: reset-loaded register array, guarded write
// port with error pulse, and a combinational read port.
module bnn_weight_table
    import bnn_pkg::*;
#(
    parameter int NUM_NEURONS = bnn_pkg::NUM_NEURONS,
    parameter int IDX_W       = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_addr,
    input  logic [7:0]       wr_data,
    input  logic             busy,
    input  logic [IDX_W-1:0] rd_addr,
    output logic [7:0]       rd_data,
    output logic             wr_err
);

    localparam logic [IDX_W:0] ADDR_LIMIT = (IDX_W + 1)'(NUM_NEURONS);

    logic [7:0] mem [NUM_NEURONS];
    logic       addr_ok;
    logic       wr_ok;

    assign addr_ok = ({1'b0, wr_addr} < ADDR_LIMIT);
    assign wr_ok   = wr_en && !busy && addr_ok;

    // A write accepted on the edge that starts a stream must reach the first
    // nibble, so the write data is forwarded onto the read port.
    assign rd_data = (wr_ok && (wr_addr == rd_addr)) ? wr_data : mem[rd_addr];

    // Table storage and write-error pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_NEURONS; i++) begin
                mem[i] <= default_weight(i);
            end
            wr_err <= 1'b0;
        end else begin
            wr_err <= wr_en && !wr_ok;
            if (wr_ok) begin
                mem[wr_addr] <= wr_data;
            end
        end
    end

endmodule

// File: rtl/bnn_weight_streamer.sv
// Host-side weight streamer: sends the weight table to the BNN core as
// low/high nibble strobes per neuron, with optional idle gaps between words.
module bnn_weight_streamer
    import bnn_pkg::*;
#(
    parameter int NUM_NEURONS = bnn_pkg::NUM_NEURONS,
    parameter int GAP_CYCLES  = 0,
    parameter int IDX_W       = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_addr,
    input  logic [7:0]       wr_data,
    input  logic             start,
    input  logic             abort,
    input  logic             tgt_ena,
    output logic [3:0]       w_nibble,
    output logic             load_en,
    output logic [IDX_W-1:0] word_idx,
    output logic             busy,
    output logic             done,
    output logic             wr_err
);

    localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

    stream_state_t    state;
    logic [GAP_W-1:0] gap_cnt;
    logic [IDX_W-1:0] next_idx;
    logic [IDX_W-1:0] rd_addr;
    logic [7:0]       rd_data;
    logic             is_last;

    assign is_last  = (word_idx == LAST_IDX);
    assign next_idx = word_idx + 1'b1;

    // HI and GAP pre-fetch the next word so its low nibble is ready on the
    // transition into LO; the last word never advances past the table.
    assign rd_addr = ((state == HI || state == GAP) && !is_last) ? next_idx : word_idx;

    bnn_weight_table #(
        .NUM_NEURONS (NUM_NEURONS),
        .IDX_W       (IDX_W)
    ) u_table (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .busy    (busy),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .wr_err  (wr_err)
    );

    // Stream sequencing, gap counting and registered strobe outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            gap_cnt  <= '0;
            w_nibble <= '0;
            load_en  <= 1'b0;
            word_idx <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort && state != IDLE) begin
                state    <= IDLE;
                load_en  <= 1'b0;
                busy     <= 1'b0;
                word_idx <= '0;
                w_nibble <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && !abort) begin
                            state    <= LO;
                            busy     <= 1'b1;
                            load_en  <= 1'b1;
                            word_idx <= '0;
                            w_nibble <= rd_data[3:0];
                        end
                    end
                    LO: begin
                        if (tgt_ena) begin
                            state    <= HI;
                            w_nibble <= rd_data[7:4];
                        end
                    end
                    HI: begin
                        if (tgt_ena) begin
                            if (is_last) begin
                                state    <= IDLE;
                                load_en  <= 1'b0;
                                busy     <= 1'b0;
                                done     <= 1'b1;
                                word_idx <= '0;
                                w_nibble <= '0;
                            end else if (GAP_CYCLES == 0) begin
                                state    <= LO;
                                word_idx <= next_idx;
                                w_nibble <= rd_data[3:0];
                            end else begin
                                state   <= GAP;
                                load_en <= 1'b0;
                                gap_cnt <= GAP_W'(GAP_CYCLES);
                            end
                        end
                    end
                    GAP: begin
                        if (gap_cnt == GAP_W'(1)) begin
                            state    <= LO;
                            load_en  <= 1'b1;
                            word_idx <= next_idx;
                            w_nibble <= rd_data[3:0];
                        end else begin
                            gap_cnt <= gap_cnt - GAP_W'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bnn_weight_streamer.sv
// Directed bench for bnn_weight_streamer: a no-gap instance and a
// GAP_CYCLES=2 instance, with a small BNN-core receiver model.
module tb_bnn_weight_streamer;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       start, start2, abort, tgt_ena;

    logic [3:0] w_nibble1, w_nibble2;
    logic       load_en1, load_en2;
    logic [3:0] word_idx1, word_idx2;
    logic       busy1, busy2, done1, done2, wr_err1, wr_err2;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_w [12];
    logic [7:0] rx_w  [12];
    logic [3:0] nib_q [$];
    int         gap_after [12];
    int         rx_cnt;
    bit         rx_phase;
    logic [3:0] rx_low;
    int         cap_busy, cap_le, cap_done;
    bit         cap_last_le;

    always #5 clk = ~clk;

    bnn_weight_streamer #(
        .NUM_NEURONS (12),
        .GAP_CYCLES  (0),
        .IDX_W       (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .start    (start),
        .abort    (abort),
        .tgt_ena  (tgt_ena),
        .w_nibble (w_nibble1),
        .load_en  (load_en1),
        .word_idx (word_idx1),
        .busy     (busy1),
        .done     (done1),
        .wr_err   (wr_err1)
    );

    bnn_weight_streamer #(
        .NUM_NEURONS (12),
        .GAP_CYCLES  (2),
        .IDX_W       (4)
    ) dut_gap (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (1'b0),
        .wr_addr  (4'd0),
        .wr_data  (8'd0),
        .start    (start2),
        .abort    (1'b0),
        .tgt_ena  (tgt_ena),
        .w_nibble (w_nibble2),
        .load_en  (load_en2),
        .word_idx (word_idx2),
        .busy     (busy2),
        .done     (done2),
        .wr_err   (wr_err2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_defaults();
        exp_w = '{8'hA0, 8'h41, 8'h7A, 8'h18, 8'hED, 8'hB7,
                  8'h67, 8'h3A, 8'hF9, 8'h62, 8'hF7, 8'h0F};
    endtask

    task automatic pulse_start(input bit sel);
        if (sel) start2 = 1'b1; else start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        start2 = 1'b0;
    endtask

    // Runs one stream to completion/abort, driving tgt_ena/abort and
    // feeding the receiver model with every consumed strobe.
    task automatic capture(input bit sel, input int stall_word, input int stall_len,
                           input int abort_word);
        int  stall_left;
        bit  ended;
        bit  aborted;
        bit  b, le, dn;
        logic [3:0] nib, idx;
        stall_left = stall_len;
        ended = 1'b0;
        aborted = 1'b0;
        cap_busy = 0; cap_le = 0; cap_done = 0; cap_last_le = 1'b0;
        rx_cnt = 0; rx_phase = 1'b0; rx_low = '0;
        nib_q.delete();
        for (int i = 0; i < 12; i++) begin
            gap_after[i] = 0;
            rx_w[i] = 8'h00;
        end
        for (int cyc = 0; cyc < 100; cyc++) begin
            b   = sel ? busy2     : busy1;
            le  = sel ? load_en2  : load_en1;
            dn  = sel ? done2     : done1;
            nib = sel ? w_nibble2 : w_nibble1;
            idx = sel ? word_idx2 : word_idx1;
            if (dn) cap_done++;
            if (!b && cyc > 0) begin
                cap_last_le = le;
                ended = 1'b1;
                break;
            end
            if (b) cap_busy++;
            if (le) cap_le++;
            if (b && !le && rx_cnt >= 1 && rx_cnt <= 12) gap_after[rx_cnt-1]++;
            tgt_ena = 1'b1;
            abort   = 1'b0;
            if (stall_left > 0 && le && int'(idx) == stall_word && rx_phase) begin
                tgt_ena = 1'b0;
                stall_left--;
            end
            if (!aborted && abort_word >= 0 && le && int'(idx) == abort_word && !rx_phase) begin
                abort   = 1'b1;
                aborted = 1'b1;
            end
            if (le && tgt_ena && !abort) begin
                nib_q.push_back(nib);
                if (!rx_phase) begin
                    rx_low   = nib;
                    rx_phase = 1'b1;
                end else begin
                    if (rx_cnt < 12) rx_w[rx_cnt] = {nib, rx_low};
                    rx_cnt++;
                    rx_phase = 1'b0;
                end
            end
            @(negedge clk);
        end
        abort   = 1'b0;
        tgt_ena = 1'b1;
        check("stream_ended", ended, 1'b1);
    endtask

    task automatic check_stream(input string tag);
        logic [7:0] w;
        logic [3:0] e;
        check({tag, "_nstrobes"}, nib_q.size(), 24);
        for (int k = 0; k < 24 && k < nib_q.size(); k++) begin
            w = exp_w[k/2];
            e = (k % 2 == 1) ? w[7:4] : w[3:0];
            check($sformatf("%s_nib%0d", tag, k), nib_q[k], e);
        end
        for (int k = 0; k < 12; k++) begin
            check($sformatf("%s_core_w%0d", tag, k), rx_w[k], exp_w[k]);
        end
    endtask

    initial begin
        int n;
        bit found;
        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        start = 1'b0; start2 = 1'b0; abort = 1'b0; tgt_ena = 1'b1;
        set_defaults();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_nibble", w_nibble1, 4'h0);
        check("rst_load_en", load_en1, 1'b0);
        check("rst_word_idx", word_idx1, 4'h0);
        check("rst_busy", busy1, 1'b0);
        check("rst_done", done1, 1'b0);
        check("rst_wr_err", wr_err1, 1'b0);

        // Default stream, no gaps
        pulse_start(1'b0);
        capture(1'b0, -1, 0, -1);
        check("t1_busy", cap_busy, 24);
        check("t1_le", cap_le, 24);
        check("t1_done", cap_done, 1);
        check_stream("t1");
        @(negedge clk);
        check("t1_done_width", done1, 1'b0);

        // GAP_CYCLES=2 instance
        pulse_start(1'b1);
        capture(1'b1, -1, 0, -1);
        check("gap_busy", cap_busy, 46);
        check("gap_le", cap_le, 24);
        check("gap_done", cap_done, 1);
        for (int k = 0; k < 12; k++) begin
            check($sformatf("gap_after%0d", k), gap_after[k], (k < 11) ? 2 : 0);
        end
        check_stream("gap");

        // Write word 3 then stream
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 8'h5C;
        @(negedge clk);
        wr_en = 1'b0;
        check("t2_wr_err", wr_err1, 1'b0);
        exp_w[3] = 8'h5C;
        pulse_start(1'b0);
        capture(1'b0, -1, 0, -1);
        check("t2_strobe7", nib_q[6], 4'hC);
        check("t2_strobe8", nib_q[7], 4'h5);
        check_stream("t2");

        // Stall 3 cycles in HI of word 5
        pulse_start(1'b0);
        capture(1'b0, 5, 3, -1);
        check("t3_busy", cap_busy, 27);
        check("t3_le", cap_le, 27);
        check("t3_done", cap_done, 1);
        check_stream("t3");

        // Write while busy is dropped
        pulse_start(1'b0);
        wr_en = 1'b1; wr_addr = 4'd2; wr_data = 8'h33;
        @(negedge clk);
        wr_en = 1'b0;
        check("t5_busy_wr_err", wr_err1, 1'b1);
        @(negedge clk);
        check("t5_busy_wr_err_clr", wr_err1, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (!busy1) begin found = 1'b1; break; end
            @(negedge clk);
        end
        check("t5_idle_reached", found, 1'b1);
        // Out-of-range write while idle is dropped
        wr_en = 1'b1; wr_addr = 4'd12; wr_data = 8'hFF;
        @(negedge clk);
        wr_en = 1'b0;
        check("t5_addr12_wr_err", wr_err1, 1'b1);
        @(negedge clk);
        check("t5_addr12_wr_err_clr", wr_err1, 1'b0);
        // Write on the same edge as start reaches this stream
        wr_en = 1'b1; wr_addr = 4'd0; wr_data = 8'h5A; start = 1'b1;
        @(negedge clk);
        wr_en = 1'b0; start = 1'b0;
        check("t5_start_wr_err", wr_err1, 1'b0);
        exp_w[0] = 8'h5A;
        capture(1'b0, -1, 0, -1);
        check_stream("t5");

        // start and abort together: abort wins
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("sa_busy", busy1, 1'b0);
        check("sa_load_en", load_en1, 1'b0);

        // Abort in LO of word 7
        pulse_start(1'b0);
        capture(1'b0, -1, 0, 7);
        check("ab_busy", cap_busy, 15);
        check("ab_le_after", cap_last_le, 1'b0);
        check("ab_no_done", cap_done, 0);
        @(negedge clk);
        check("ab_done_later", done1, 1'b0);

        // Reset during HI of word 4
        pulse_start(1'b0);
        n = 0;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (load_en1) n++;
            if (n == 10) begin found = 1'b1; break; end
            @(negedge clk);
        end
        check("rs_reached", found, 1'b1);
        check("rs_hi_nibble", w_nibble1, 4'hE);
        check("rs_hi_idx", word_idx1, 4'd4);
        #2 reset = 1'b1;
        #1;
        check("rs_load_en_async", load_en1, 1'b0);
        check("rs_busy_async", busy1, 1'b0);
        check("rs_idx_async", word_idx1, 4'd0);
        @(negedge clk);
        reset = 1'b0;
        set_defaults();
        @(negedge clk);
        pulse_start(1'b0);
        capture(1'b0, -1, 0, -1);
        check("rs_done", cap_done, 1);
        check_stream("rs");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
